// File: rtl/bullet_spawn_scheduler.sv
// Purpose: schedules enemy-bullet spawns (round-robin over alive enemies, up to
//          SHOTS_PER_PHASE per phase) and rate-limited player-bullet spawns.
// Latency: spawn pulses are registered, one cycle after the scan/press decision.
// Backpressure: none; a full slot mask ends the enemy scan, and a blocked press is dropped.
//
// Ports:
//   i_Clk, i_Rst           clock, synchronous active-low reset
//   i_Tick                 game-step enable pulse (phase counter, player cooldown)
//   i_EnemyState           alive mask, one bit per enemy
//   i_EnemyBulletState     occupied enemy-bullet slots (from datapath)
//   i_PlayerState          player alive
//   i_PlayerBulletState    occupied player-bullet slots (from datapath)
//   i_fPlayerShoot         synchronised shoot button level
//   o_fEnemySpawn/Src/Slot enemy-bullet spawn pulse, source enemy, target slot
//   o_fPlayerSpawn/Slot    player-bullet spawn pulse, target slot
//   o_Phase, o_fPhaseStart current phase (mod 4), one-cycle phase-change pulse
//   o_fBusy                enemy scan in progress
module bullet_spawn_scheduler #(
  parameter int MAX_ENEMY         = 15,
  parameter int MAX_ENEMY_BULLET  = 30,
  parameter int MAX_PLAYER_BULLET = 15,
  parameter int PHASE_TICKS       = 128,
  parameter int SHOTS_PER_PHASE   = 3,
  parameter int PLAYER_COOLDOWN   = 8
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst,
  input  logic                         i_Tick,
  input  logic [MAX_ENEMY-1:0]         i_EnemyState,
  input  logic [MAX_ENEMY_BULLET-1:0]  i_EnemyBulletState,
  input  logic                         i_PlayerState,
  input  logic [MAX_PLAYER_BULLET-1:0] i_PlayerBulletState,
  input  logic                         i_fPlayerShoot,
  output logic                         o_fEnemySpawn,
  output logic [3:0]                   o_EnemySpawnSrc,
  output logic [4:0]                   o_EnemySpawnSlot,
  output logic                         o_fPlayerSpawn,
  output logic [3:0]                   o_PlayerSpawnSlot,
  output logic [1:0]                   o_Phase,
  output logic                         o_fPhaseStart,
  output logic                         o_fBusy
);

  localparam int PhW   = $clog2(PHASE_TICKS);
  localparam int ShotW = $clog2(SHOTS_PER_PHASE + 1);
  localparam int CdW   = $clog2(PLAYER_COOLDOWN + 1);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} scanState_t;

  function automatic logic [4:0] lowestEnemySlot(input logic [MAX_ENEMY_BULLET-1:0] m);
    lowestEnemySlot = '0;
    for (int i = MAX_ENEMY_BULLET - 1; i >= 0; i--)
      if (m[i]) lowestEnemySlot = 5'(i);
  endfunction

  function automatic logic [3:0] lowestPlayerSlot(input logic [MAX_PLAYER_BULLET-1:0] m);
    lowestPlayerSlot = '0;
    for (int i = MAX_PLAYER_BULLET - 1; i >= 0; i--)
      if (m[i]) lowestPlayerSlot = 4'(i);
  endfunction

  // ---------------- phase counter ----------------
  logic [PhW-1:0] phaseCnt;
  logic           phaseWrap;

  assign phaseWrap = i_Tick && (phaseCnt == PhW'(PHASE_TICKS - 1));

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      phaseCnt      <= '0;
      o_Phase       <= '0;
      o_fPhaseStart <= 1'b0;
    end else begin
      o_fPhaseStart <= phaseWrap;
      if (phaseWrap) begin
        phaseCnt <= '0;
        o_Phase  <= o_Phase + 2'd1;
      end else if (i_Tick) begin
        phaseCnt <= phaseCnt + PhW'(1);
      end
    end
  end

  // ---------------- enemy scan FSM ----------------
  scanState_t             state, stateNext;
  logic [ShotW-1:0]       shots;
  logic [3:0]             scanned;
  logic [3:0]             idx, idxNext, rrPtr;
  logic [MAX_ENEMY_BULLET-1:0] ebShadow, ebFree;
  logic                   ebAny, doSpawn, scanDone, scanStart;
  logic [4:0]             ebSlot;

  // The datapath marks a slot occupied one cycle after our pulse, so the slot
  // currently being pulsed must be masked out by hand.
  always_comb begin
    ebShadow = '0;
    if (o_fEnemySpawn) ebShadow[o_EnemySpawnSlot] = 1'b1;
  end

  assign ebFree  = ~i_EnemyBulletState & ~ebShadow;
  assign ebAny   = |ebFree;
  assign ebSlot  = lowestEnemySlot(ebFree);
  assign idxNext = (idx == 4'(MAX_ENEMY - 1)) ? 4'd0 : idx + 4'd1;
  assign o_fBusy = (state == SCAN);

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    doSpawn   = 1'b0;
    scanDone  = 1'b0;
    scanStart = 1'b0;
    case (state)
      IDLE: begin
        if (o_fPhaseStart) begin
          scanStart = 1'b1;
          stateNext = SCAN;
        end
      end
      SCAN: begin
        doSpawn  = i_EnemyState[idx] && ebAny;
        // Exit on last shot used, last enemy visited, or no slot left.
        scanDone = !ebAny
                 || (doSpawn && (shots == ShotW'(1)))
                 || (scanned == 4'(MAX_ENEMY - 1));
        if (scanDone) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      shots            <= '0;
      scanned          <= '0;
      idx              <= '0;
      rrPtr            <= '0;
      o_fEnemySpawn    <= 1'b0;
      o_EnemySpawnSrc  <= '0;
      o_EnemySpawnSlot <= '0;
    end else begin
      o_fEnemySpawn <= doSpawn;
      if (scanStart) begin
        shots   <= ShotW'(SHOTS_PER_PHASE);
        scanned <= '0;
        idx     <= rrPtr;
      end else if (state == SCAN) begin
        idx     <= idxNext;
        scanned <= scanned + 4'd1;
        if (doSpawn) begin
          o_EnemySpawnSrc  <= idx;
          o_EnemySpawnSlot <= ebSlot;
          shots            <= shots - ShotW'(1);
        end
        if (scanDone) rrPtr <= idxNext;
      end
    end
  end

  // ---------------- player channel ----------------
  logic                         shootQ, press, playerIssue;
  logic [CdW-1:0]               cooldown;
  logic [MAX_PLAYER_BULLET-1:0] pbShadow, pbFree;

  always_comb begin
    pbShadow = '0;
    if (o_fPlayerSpawn) pbShadow[o_PlayerSpawnSlot] = 1'b1;
  end

  assign pbFree      = ~i_PlayerBulletState & ~pbShadow;
  assign press       = i_fPlayerShoot && !shootQ;
  assign playerIssue = press && i_PlayerState && (cooldown == '0) && (|pbFree);

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      shootQ            <= 1'b0;
      cooldown          <= '0;
      o_fPlayerSpawn    <= 1'b0;
      o_PlayerSpawnSlot <= '0;
    end else begin
      shootQ         <= i_fPlayerShoot;
      o_fPlayerSpawn <= playerIssue;
      if (playerIssue) begin
        o_PlayerSpawnSlot <= lowestPlayerSlot(pbFree);
        cooldown          <= CdW'(PLAYER_COOLDOWN);
      end else if (i_Tick && (cooldown != '0)) begin
        cooldown <= cooldown - CdW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bullet_spawn_scheduler.sv
module tb_bullet_spawn_scheduler;
  logic        i_Clk = 1'b0;
  logic        i_Rst;
  logic        i_Tick;
  logic [14:0] i_EnemyState;
  logic [29:0] i_EnemyBulletState;
  logic        i_PlayerState;
  logic [14:0] i_PlayerBulletState;
  logic        i_fPlayerShoot;
  logic        o_fEnemySpawn;
  logic [3:0]  o_EnemySpawnSrc;
  logic [4:0]  o_EnemySpawnSlot;
  logic        o_fPlayerSpawn;
  logic [3:0]  o_PlayerSpawnSlot;
  logic [1:0]  o_Phase;
  logic        o_fPhaseStart;
  logic        o_fBusy;

  always #5 i_Clk = ~i_Clk;

  bullet_spawn_scheduler dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Tick(i_Tick),
    .i_EnemyState(i_EnemyState), .i_EnemyBulletState(i_EnemyBulletState),
    .i_PlayerState(i_PlayerState), .i_PlayerBulletState(i_PlayerBulletState),
    .i_fPlayerShoot(i_fPlayerShoot),
    .o_fEnemySpawn(o_fEnemySpawn), .o_EnemySpawnSrc(o_EnemySpawnSrc),
    .o_EnemySpawnSlot(o_EnemySpawnSlot), .o_fPlayerSpawn(o_fPlayerSpawn),
    .o_PlayerSpawnSlot(o_PlayerSpawnSlot), .o_Phase(o_Phase),
    .o_fPhaseStart(o_fPhaseStart), .o_fBusy(o_fBusy)
  );

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int phaseStarts = 0;
  int busyCycles = 0;
  int pCount = 0;
  logic [3:0] lastPSlot = '0;
  logic [3:0] srcQ[$];
  logic [4:0] slotQ[$];
  int         cycQ[$];
  logic       ebPend = 1'b0;
  logic [4:0] ebPendSlot = '0;
  logic       pbPend = 1'b0;
  logic [3:0] pbPendSlot = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {13'd0, o_fEnemySpawn, o_EnemySpawnSrc, o_EnemySpawnSlot, o_fPlayerSpawn,
            o_PlayerSpawnSlot, o_Phase, o_fPhaseStart, o_fBusy};
  endfunction

  function automatic logic [31:0] srcAt(input int i);
    return (i < srcQ.size()) ? 32'(srcQ[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] slotAt(input int i);
    return (i < slotQ.size()) ? 32'(slotQ[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] cycAt(input int i);
    return (i < cycQ.size()) ? 32'(cycQ[i]) : 32'hDEAD;
  endfunction

  // One clock: also models the datapath, which marks a slot occupied on the
  // edge after the spawn pulse.
  task automatic step();
    @(posedge i_Clk);
    #1;
    cycle++;
    if (ebPend) i_EnemyBulletState[ebPendSlot] = 1'b1;
    if (pbPend) i_PlayerBulletState[pbPendSlot] = 1'b1;
    ebPend     = o_fEnemySpawn;
    ebPendSlot = o_EnemySpawnSlot;
    pbPend     = o_fPlayerSpawn;
    pbPendSlot = o_PlayerSpawnSlot;
    if (o_fEnemySpawn) begin
      srcQ.push_back(o_EnemySpawnSrc);
      slotQ.push_back(o_EnemySpawnSlot);
      cycQ.push_back(cycle);
    end
    if (o_fPhaseStart) phaseStarts++;
    if (o_fBusy) busyCycles++;
    if (o_fPlayerSpawn) begin
      pCount++;
      lastPSlot = o_PlayerSpawnSlot;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      i_Tick = 1'b1;
      step();
      i_Tick = 1'b0;
      step();
    end
  endtask

  task automatic clearLog();
    srcQ.delete();
    slotQ.delete();
    cycQ.delete();
    phaseStarts = 0;
    busyCycles  = 0;
  endtask

  task automatic doReset();
    i_Rst = 1'b0;
    step();
    step();
    i_EnemyBulletState  = '0;
    i_PlayerBulletState = '0;
    ebPend = 1'b0;
    pbPend = 1'b0;
    i_Rst = 1'b1;
    step();
  endtask

  initial begin
    i_Rst = 1'b0; i_Tick = 1'b0; i_EnemyState = '0; i_EnemyBulletState = '0;
    i_PlayerState = 1'b0; i_PlayerBulletState = '0; i_fPlayerShoot = 1'b0;
    step();
    step();
    check("reset_outputs", outs(), 32'd0);
    i_Rst = 1'b1;
    step();

    // 1: first phase, everyone alive, all slots free
    i_EnemyState = 15'h7FFF;
    clearLog();
    ticks(128);
    check("t1_phase", 32'(o_Phase), 32'd1);
    check("t1_phase_start_pulses", phaseStarts, 1);
    repeat (10) step();
    check("t1_spawn_count", srcQ.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("t1_src", srcAt(i), i);
      check("t1_slot", slotAt(i), i);
    end
    check("t1_consecutive", cycAt(2) - cycAt(0), 32'd2);
    check("t1_busy_cycles", busyCycles, 3);
    check("t1_busy_fell", 32'(o_fBusy), 32'd0);

    // 2: second phase continues round-robin, datapath now holds slots 0-2
    clearLog();
    ticks(128);
    check("t2_phase", 32'(o_Phase), 32'd2);
    repeat (10) step();
    check("t2_spawn_count", srcQ.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("t2_src", srcAt(i), i + 3);
      check("t2_slot", slotAt(i), i + 3);
    end

    // 3: only enemies 7 and 12 alive, pointer back at 0
    doReset();
    i_EnemyState = 15'h1080;
    clearLog();
    ticks(128);
    repeat (20) step();
    check("t3_spawn_count", srcQ.size(), 2);
    check("t3_src0", srcAt(0), 7);
    check("t3_src1", srcAt(1), 12);
    check("t3_slot0", slotAt(0), 0);
    check("t3_slot1", slotAt(1), 1);
    check("t3_busy_cycles", busyCycles, 15);
    i_EnemyState = 15'h7FFF;
    clearLog();
    ticks(128);
    repeat (10) step();
    check("t3_rr_wrap_src", srcAt(0), 0);
    check("t3_rr_wrap_slot", slotAt(0), 2);

    // 4: only slot 29 free; pointer now at 3
    i_EnemyBulletState = 30'h1FFF_FFFF;
    clearLog();
    ticks(128);
    repeat (10) step();
    check("t4_spawn_count", srcQ.size(), 1);
    check("t4_slot", slotAt(0), 29);
    check("t4_src", srcAt(0), 3);
    check("t4_busy_cycles", busyCycles, 2);
    check("t4_idle", 32'(o_fBusy), 32'd0);

    // 5: player channel
    i_EnemyState = '0;
    i_PlayerState = 1'b1;
    i_PlayerBulletState = '0;
    pCount = 0;
    i_fPlayerShoot = 1'b1;
    step();
    check("t5_first_pulse", 32'(o_fPlayerSpawn), 32'd1);
    check("t5_first_slot", 32'(o_PlayerSpawnSlot), 32'd0);
    i_fPlayerShoot = 1'b0;
    step();
    check("t5_pulse_one_cycle", 32'(o_fPlayerSpawn), 32'd0);
    ticks(4);
    i_fPlayerShoot = 1'b1;
    step();
    i_fPlayerShoot = 1'b0;
    step();
    check("t5_cooldown_block", pCount, 1);
    ticks(4);
    i_fPlayerShoot = 1'b1;
    step();
    check("t5_cooldown_expired_pulse", 32'(o_fPlayerSpawn), 32'd1);
    check("t5_second_slot", 32'(o_PlayerSpawnSlot), 32'd1);
    i_fPlayerShoot = 1'b0;
    step();
    ticks(8);
    pCount = 0;
    i_fPlayerShoot = 1'b1;
    ticks(25);
    check("t5_hold_single", pCount, 1);
    check("t5_hold_slot", 32'(lastPSlot), 32'd2);
    i_fPlayerShoot = 1'b0;
    step();
    i_PlayerState = 1'b0;
    i_fPlayerShoot = 1'b1;
    step();
    step();
    i_fPlayerShoot = 1'b0;
    step();
    check("t5_dead_block", pCount, 1);

    // 6: reset in the middle of a scan
    doReset();
    i_EnemyState = 15'h7FFF;
    clearLog();
    ticks(128);
    step();
    check("t6_pre_reset_spawn", srcQ.size(), 1);
    i_Rst = 1'b0;
    step();
    check("t6_rst_outputs", outs(), 32'd0);
    i_Rst = 1'b1;
    clearLog();
    repeat (40) step();
    check("t6_no_spawn", srcQ.size(), 0);
    check("t6_phase", 32'(o_Phase), 32'd0);
    check("t6_idle", busyCycles, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
